// File: rtl/fifo_word_packer.sv
// Packs PACK_RATIO FIFO entries into one word; FIFO_WORD_PACKER_MSB_FIRST_EN puts first entry in top lane.
// Latency: word valid 5 cycles after its first read (PACK_RATIO=4), flush emits once in-flight read lands.
// Backpressure: completed word waits in assembly register and reads stop until the output slot frees.
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]            fifo_data,
    input  logic                             flush,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [CNT_WIDTH-1:0]             out_lanes,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int                   WORD_W   = DATA_WIDTH * PACK_RATIO;
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_RATIO);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PACK_RATIO - 1);
    localparam logic [CNT_WIDTH:0]   LIMIT    = (CNT_WIDTH + 1)'(PACK_RATIO);

    logic [WORD_W-1:0]    asm_q;
    logic [WORD_W-1:0]    asm_merged;
    logic [CNT_WIDTH-1:0] lane_cnt;
    logic [CNT_WIDTH-1:0] lane_idx;
    logic [CNT_WIDTH:0]   occupancy;
    logic                 inflight;
    logic                 pending_flush;
    logic                 slot_free;
    logic                 complete_now;
    logic                 drain_held;
    logic                 flush_emit;
    logic                 load_out;
    logic                 flush_done;

    always_comb begin
        occupancy  = {1'b0, lane_cnt} + {{CNT_WIDTH{1'b0}}, inflight};
        fifo_rd_en = !rst && !fifo_empty && !pending_flush && (occupancy < LIMIT);

`ifdef FIFO_WORD_PACKER_MSB_FIRST_EN
        lane_idx = LAST_CNT - lane_cnt;
`else
        lane_idx = lane_cnt;
`endif

        asm_merged = asm_q;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (lane_idx == CNT_WIDTH'(k)) begin
                asm_merged[k*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
            end
        end

        slot_free    = !out_valid || out_ready;
        // Landing entry completes the word and can go straight to the output register.
        complete_now = inflight && (lane_cnt == LAST_CNT) && slot_free;
        // A full word parked by backpressure moves out as soon as the slot frees.
        drain_held   = !inflight && (lane_cnt == FULL_CNT) && slot_free;
        flush_emit   = pending_flush && !inflight && slot_free && (lane_cnt != '0);
        load_out     = complete_now || drain_held || flush_emit;
        flush_done   = pending_flush && !inflight && ((lane_cnt == '0) || load_out);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q         <= '0;
            lane_cnt      <= '0;
            inflight      <= 1'b0;
            pending_flush <= 1'b0;
            out_data      <= '0;
            out_lanes     <= '0;
            out_valid     <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= complete_now ? asm_merged : asm_q;
                out_lanes <= complete_now ? FULL_CNT : lane_cnt;
                asm_q     <= '0;
                lane_cnt  <= '0;
            end else begin
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
                if (inflight) begin
                    asm_q    <= asm_merged;
                    lane_cnt <= lane_cnt + CNT_WIDTH'(1);
                end
            end

            if (flush_done) begin
                pending_flush <= 1'b0;
            end else if (flush) begin
                pending_flush <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural FIFO, byte-stream-to-word reference model, handshake scoreboard.
module tb_fifo_word_packer;

    localparam int DW = 8;
    localparam int PR = 4;
    localparam int CW = 3;
    localparam int WW = DW * PR;

    logic          clk;
    logic          rst;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data;
    logic          flush;
    logic [WW-1:0] out_data;
    logic [CW-1:0] out_lanes;
    logic          out_valid;
    logic          out_ready;

    fifo_word_packer #(
        .DATA_WIDTH(DW),
        .PACK_RATIO(PR),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .flush     (flush),
        .out_data  (out_data),
        .out_lanes (out_lanes),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pkt_q[$];
    logic [WW-1:0] exp_data_q[$];
    int            exp_lanes_q[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt, vld_cnt, acc_cnt, first_rd, first_vld, acc_prev, acc_last;
    bit rnd_rdy = 0;
    bit prev_stall = 0;
    logic [WW-1:0] prev_data;
    logic [CW-1:0] prev_lanes;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: every PR bytes pushed form one word; a flush emits whatever remains.
    task automatic emit_expected();
        logic [WW-1:0] w;
        int n;
        w = '0;
        n = pkt_q.size();
        for (int k = 0; k < n; k++) begin
`ifdef FIFO_WORD_PACKER_MSB_FIRST_EN
            w[(PR-1-k)*DW +: DW] = pkt_q[k];
`else
            w[k*DW +: DW] = pkt_q[k];
`endif
        end
        exp_data_q.push_back(w);
        exp_lanes_q.push_back(n);
        pkt_q.delete();
    endtask

    task automatic push(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
        pkt_q.push_back(b);
        if (pkt_q.size() == PR) emit_expected();
    endtask

    task automatic clr_stats();
        rd_cnt = 0; vld_cnt = 0; acc_cnt = 0;
        first_rd = -1; first_vld = -1; acc_prev = -1; acc_last = -1;
    endtask

    // One clock cycle: entered at a falling edge with inputs applied.
    task automatic tick();
        bit rd;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        #1;
        if (fifo_empty) chk("no_underflow", 64'(fifo_rd_en), 64'(0));
        if (rst) chk("rd_en_in_reset", 64'(fifo_rd_en), 64'(0));
        if (prev_stall && !rst) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(prev_data));
            chk("hold_lanes", 64'(out_lanes), 64'(prev_lanes));
        end
        if (out_valid) begin
            vld_cnt++;
            if (first_vld < 0) first_vld = cyc;
        end
        if (out_valid && out_ready && !rst) begin
            acc_cnt++;
            acc_prev = acc_last;
            acc_last = cyc;
            if (exp_data_q.size() == 0) begin
                chk("extra_word_lanes", 64'(out_lanes), 64'(0));
            end else begin
                chk("word_data", 64'(out_data), 64'(exp_data_q.pop_front()));
                chk("word_lanes", 64'(out_lanes), 64'(exp_lanes_q.pop_front()));
            end
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_data  = out_data;
        prev_lanes = out_lanes;
        rd = fifo_rd_en;
        if (rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rd && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        flush = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_flush();
        int t = 0;
        while (fifo_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        if (fifo_q.size() != 0) chk("drain_timeout", 64'(fifo_q.size()), 64'(0));
        ticks(2);
        flush = 1'b1;
        if (pkt_q.size() != 0) emit_expected();
        tick();
    endtask

    task automatic wait_idle();
        int t = 0;
        while (exp_data_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        if (exp_data_q.size() != 0) chk("idle_timeout", 64'(exp_data_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; fifo_empty = 1'b1; fifo_data = '0; flush = 1'b0; out_ready = 1'b1;
        clr_stats();
        @(negedge clk);

        // Reset state; bytes already waiting must not be read under reset.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        ticks(2);
        #1;
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_data", 64'(out_data), 64'(0));
        chk("reset_lanes", 64'(out_lanes), 64'(0));
        chk("reset_rd_en", 64'(fifo_rd_en), 64'(0));

        // Basic packing and first-word latency.
        rst = 1'b0;
        clr_stats();
        ticks(12);
        chk("basic_reads", 64'(rd_cnt), 64'(4));
        chk("basic_valid_cycles", 64'(vld_cnt), 64'(1));
        chk("basic_latency", 64'(first_vld - first_rd), 64'(5));

        // Continuous stream of 12 bytes.
        clr_stats();
        for (int i = 1; i <= 12; i++) push(DW'(i));
        ticks(25);
        chk("stream_reads", 64'(rd_cnt), 64'(12));
        chk("stream_words", 64'(acc_cnt), 64'(3));

        // Backpressure: two words, reads stop after eight entries.
        out_ready = 1'b0;
        clr_stats();
        for (int i = 0; i < 8; i++) push(DW'(8'hA0 + i));
        ticks(20);
        chk("bp_reads", 64'(rd_cnt), 64'(8));
        chk("bp_no_accept", 64'(acc_cnt), 64'(0));
        out_ready = 1'b1;
        clr_stats();
        ticks(4);
        chk("bp_words", 64'(acc_cnt), 64'(2));
        chk("bp_back_to_back", 64'(acc_last - acc_prev), 64'(1));

        // Partial flush, then a flush with nothing assembled.
        clr_stats();
        push(8'hAA); push(8'hBB); push(8'hCC);
        do_flush();
        ticks(5);
        chk("flush_words", 64'(acc_cnt), 64'(1));
        clr_stats();
        flush = 1'b1;
        ticks(10);
        chk("empty_flush_valid", 64'(vld_cnt), 64'(0));

        // Reset with two lanes captured and one read in flight.
        push(8'h5A); push(8'h5B); push(8'h5C);
        ticks(3);
        rst = 1'b1;
        tick();
        #1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_data", 64'(out_data), 64'(0));
        chk("midrst_lanes", 64'(out_lanes), 64'(0));
        rst = 1'b0;
        prev_stall = 0;
        pkt_q.delete();
        exp_data_q.delete();
        exp_lanes_q.delete();
        clr_stats();
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        ticks(10);
        chk("midrst_words", 64'(acc_cnt), 64'(1));

        // Randomized packets with random downstream readiness.
        rnd_rdy = 1;
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(1, 11);
            for (int i = 0; i < len; i++) begin
                push(DW'($urandom));
                if ($urandom_range(0, 1) == 1) tick();
            end
            if ($urandom_range(0, 2) != 0) do_flush();
        end
        do_flush();
        rnd_rdy = 0;
        out_ready = 1'b1;
        wait_idle();
        ticks(5);
        chk("final_pending_words", 64'(exp_data_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
